// File: rtl/space_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard decoder: FSM states,
// prefix bytes and the default scan codes.
package space_kbd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GOT_E0,
        GOT_F0
    } kbd_state_t;

    localparam logic [7:0] KBD_EXT            = 8'hE0;
    localparam logic [7:0] KBD_BRK            = 8'hF0;
    localparam logic [7:0] KBD_LEFT_CODE      = 8'h6B;
    localparam logic [7:0] KBD_RIGHT_CODE     = 8'h74;
    localparam logic [7:0] KBD_ENTER_CODE     = 8'h5A;
    localparam int         KBD_TIMEOUT_CYCLES = 1_000_000;

endpackage

// File: rtl/kbd_prefix_timer.sv
// Saturating prefix-wait counter: cleared on every strobe, counts while a
// prefix is pending, and flags expiry on the cycle its count is TIMEOUT_CYCLES-1.
module kbd_prefix_timer
    import space_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = KBD_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic resetN,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == CNT_LAST);
    assign o_expire  = i_enable && w_at_last;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_count <= '0;
        end else if (i_clear || o_expire) begin
            r_count <= '0;
        end else if (i_enable && !w_at_last) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/kbd_key_decoder.sv
// PS/2 scan-code decoder: tracks E0/F0 prefixes and turns arrow/Enter
// make/break codes into level outputs plus a one-shot Enter pulse.
module kbd_key_decoder
    import space_kbd_pkg::*;
#(
    parameter logic [7:0] LEFT_CODE      = KBD_LEFT_CODE,
    parameter logic [7:0] RIGHT_CODE     = KBD_RIGHT_CODE,
    parameter logic [7:0] ENTER_CODE     = KBD_ENTER_CODE,
    parameter int         TIMEOUT_CYCLES = KBD_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       clear,
    input  logic       din_new,
    input  logic [7:0] din,
    output logic       leftArrow,
    output logic       rightArrow,
    output logic       enter,
    output logic       enterPulse,
    output logic       prefixBusy
);

    kbd_state_t r_state;
    logic       r_ext;
    logic       r_brk;
    logic       r_left;
    logic       r_right;
    logic       r_enter;
    logic       r_enter_pulse;
    logic       w_busy;
    logic       w_expire;

    assign w_busy = (r_state != IDLE);

    kbd_prefix_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_prefix_timer (
        .clk     (clk),
        .resetN  (resetN),
        .i_clear (clear || din_new),
        .i_enable(w_busy && !din_new),
        .o_expire(w_expire)
    );

    // NOTE: every control and output flop is reset; there is no storage array
    // here, so nothing is left to power up undefined.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= IDLE;
            r_ext         <= 1'b0;
            r_brk         <= 1'b0;
            r_left        <= 1'b0;
            r_right       <= 1'b0;
            r_enter       <= 1'b0;
            r_enter_pulse <= 1'b0;
        end else if (clear) begin
            r_state       <= IDLE;
            r_ext         <= 1'b0;
            r_brk         <= 1'b0;
            r_left        <= 1'b0;
            r_right       <= 1'b0;
            r_enter       <= 1'b0;
            r_enter_pulse <= 1'b0;
        end else begin
            r_enter_pulse <= 1'b0;
            if (din_new) begin
                case (din)
                    KBD_EXT: begin
                        r_state <= GOT_E0;
                        r_ext   <= 1'b1;
                        r_brk   <= 1'b0;
                    end
                    KBD_BRK: begin
                        r_state <= GOT_F0;
                        r_brk   <= 1'b1;
                    end
                    default: begin
                        // Arrows exist only as extended codes; bare 6B/74 are numpad keys.
                        if (din == LEFT_CODE && r_ext)  r_left  <= !r_brk;
                        if (din == RIGHT_CODE && r_ext) r_right <= !r_brk;
                        if (din == ENTER_CODE) begin
                            r_enter <= !r_brk;
                            if (!r_brk && !r_enter) r_enter_pulse <= 1'b1;
                        end
                        r_state <= IDLE;
                        r_ext   <= 1'b0;
                        r_brk   <= 1'b0;
                    end
                endcase
            end else if (w_expire) begin
                r_state <= IDLE;
                r_ext   <= 1'b0;
                r_brk   <= 1'b0;
            end
        end
    end

    assign leftArrow  = r_left;
    assign rightArrow = r_right;
    assign enter      = r_enter;
    assign enterPulse = r_enter_pulse;
    assign prefixBusy = w_busy;

endmodule
